// File: rtl/dead_time_pkg.sv
// Shared encodings for the gate-bus dead-time monitor: leg FSM states,
// last-on-switch memory and gate-bus bit positions.
package dead_time_pkg;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_HIGH  = 2'd1,
        ST_LOW   = 2'd2,
        ST_SHOOT = 2'd3
    } leg_state_t;

    typedef enum logic [1:0] {
        PREV_NONE = 2'd0,
        PREV_HIGH = 2'd1,
        PREV_LOW  = 2'd2
    } prev_t;

    localparam int LEG0_HIGH = 0;
    localparam int LEG0_LOW  = 1;
    localparam int LEG1_HIGH = 2;
    localparam int LEG1_LOW  = 3;

endpackage

// File: rtl/dead_time_leg_monitor.sv
// One half-bridge leg observer: tracks on/off/shoot state, measures the
// both-off interval at each complementary commutation and latches faults.
module dead_time_leg_monitor
    import dead_time_pkg::*;
#(
    parameter int MIN_DEADTIME = 10,
    parameter int CNT_WIDTH    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 high,
    input  logic                 low,
    input  logic                 clear,
    output logic [CNT_WIDTH-1:0] dt,
    output logic                 dt_valid,
    output logic                 fault_shoot,
    output logic                 fault_dt
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    leg_state_t           state;
    prev_t                prev;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 from_shoot;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
        return (c == '1) ? c : c + CNT_ONE;
    endfunction

    function automatic logic too_short(input logic [CNT_WIDTH-1:0] c);
        return longint'({1'b0, c}) < longint'(MIN_DEADTIME);
    endfunction

    // An on-period entered straight out of SHOOT is untrusted, so turning it
    // off leaves prev at NONE and the following commutation goes unmeasured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_OFF;
            prev        <= PREV_NONE;
            cnt         <= '0;
            from_shoot  <= 1'b0;
            dt          <= '0;
            dt_valid    <= 1'b0;
            fault_shoot <= 1'b0;
            fault_dt    <= 1'b0;
        end else begin
            dt_valid <= 1'b0;
            if (clear) begin
                fault_shoot <= 1'b0;
                fault_dt    <= 1'b0;
            end
            if (high && low) begin
                state       <= ST_SHOOT;
                prev        <= PREV_NONE;
                fault_shoot <= 1'b1;
            end else begin
                unique case (state)
                    ST_OFF: begin
                        if (!high && !low) begin
                            cnt <= sat_inc(cnt);
                        end else begin
                            state <= high ? ST_HIGH : ST_LOW;
                            if ((high && prev == PREV_LOW) || (low && prev == PREV_HIGH)) begin
                                dt       <= cnt;
                                dt_valid <= 1'b1;
                                if (too_short(cnt)) fault_dt <= 1'b1;
                            end
                        end
                    end
                    ST_HIGH, ST_LOW: begin
                        if (!high && !low) begin
                            state      <= ST_OFF;
                            cnt        <= CNT_ONE;
                            from_shoot <= 1'b0;
                            if (from_shoot)
                                prev <= PREV_NONE;
                            else
                                prev <= (state == ST_HIGH) ? PREV_HIGH : PREV_LOW;
                        end else if ((state == ST_HIGH && low) || (state == ST_LOW && high)) begin
                            state      <= high ? ST_HIGH : ST_LOW;
                            from_shoot <= 1'b0;
                            dt         <= '0;
                            dt_valid   <= 1'b1;
                            if (too_short('0)) fault_dt <= 1'b1;
                        end
                    end
                    ST_SHOOT: begin
                        prev <= PREV_NONE;
                        if (!high && !low) begin
                            state      <= ST_OFF;
                            cnt        <= CNT_ONE;
                            from_shoot <= 1'b0;
                        end else begin
                            state      <= high ? ST_HIGH : ST_LOW;
                            from_shoot <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/dead_time_monitor_4bit.sv
// Full-bridge gate-bus observer: registers the 4-bit gate bus, runs one
// independent monitor per leg and registers the combined fault flag.
module dead_time_monitor_4bit
    import dead_time_pkg::*;
#(
    parameter int MIN_DEADTIME = 10,
    parameter int CNT_WIDTH    = 8
) (
    input  logic                 i_clock,
    input  logic                 i_reset_n,
    input  logic [3:0]           i_signal,
    input  logic                 i_clear,
    output logic [CNT_WIDTH-1:0] o_dt_leg0,
    output logic [CNT_WIDTH-1:0] o_dt_leg1,
    output logic [1:0]           o_dt_valid,
    output logic [1:0]           o_fault_shoot,
    output logic [1:0]           o_fault_dt,
    output logic                 o_fault
);

    logic [3:0] s_q;

    // Input sample stage
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) s_q <= '0;
        else            s_q <= i_signal;
    end

    dead_time_leg_monitor #(
        .MIN_DEADTIME(MIN_DEADTIME),
        .CNT_WIDTH   (CNT_WIDTH)
    ) u_leg0 (
        .clk        (i_clock),
        .rst_n      (i_reset_n),
        .high       (s_q[LEG0_HIGH]),
        .low        (s_q[LEG0_LOW]),
        .clear      (i_clear),
        .dt         (o_dt_leg0),
        .dt_valid   (o_dt_valid[0]),
        .fault_shoot(o_fault_shoot[0]),
        .fault_dt   (o_fault_dt[0])
    );

    dead_time_leg_monitor #(
        .MIN_DEADTIME(MIN_DEADTIME),
        .CNT_WIDTH   (CNT_WIDTH)
    ) u_leg1 (
        .clk        (i_clock),
        .rst_n      (i_reset_n),
        .high       (s_q[LEG1_HIGH]),
        .low        (s_q[LEG1_LOW]),
        .clear      (i_clear),
        .dt         (o_dt_leg1),
        .dt_valid   (o_dt_valid[1]),
        .fault_shoot(o_fault_shoot[1]),
        .fault_dt   (o_fault_dt[1])
    );

    // Fault summary stage
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) o_fault <= 1'b0;
        else            o_fault <= |{o_fault_shoot, o_fault_dt};
    end

endmodule

// File: doc/dead_time_monitor_4bit.md
# dead_time_monitor_4bit

Checks the four gate signals of the full bridge after dead-time insertion: measures, per leg, the both-off interval at every complementary commutation, and flags shoot-through and dead-time violations. It sits on the 4-bit gate bus between the dead-time inserter and the output pins, in parallel with the pins. It acts as a protection and debug observer and never modifies the gate signals.

## Interface
Parameters:
- MIN_DEADTIME, 10, minimum legal both-off interval in clock cycles.
- CNT_WIDTH, 8, width of the dead-time counters and reported values.

Ports:
- i_clock  in  1  system clock, same clock as the dead-time inserter.
- i_reset_n  in  1  reset, asynchronous, active-low.
- i_signal  in  4  gate bus: [0] leg0 high, [1] leg0 low, [2] leg1 high, [3] leg1 low.
- i_clear  in  1  synchronous clear of the latched faults.
- o_dt_leg0  out  CNT_WIDTH  last measured dead time of leg0, in cycles.
- o_dt_leg1  out  CNT_WIDTH  last measured dead time of leg1, in cycles.
- o_dt_valid  out  2  one-cycle pulse per leg when the matching o_dt_legN updates.
- o_fault_shoot  out  2  latched shoot-through fault per leg.
- o_fault_dt  out  2  latched dead-time-too-short fault per leg.
- o_fault  out  1  OR of all four fault bits, registered.

## Operation
- i_signal is registered once (s_q); each leg FSM runs on its 2-bit pair of s_q.
- States: OFF (00), HIGH (10 on {low,high}=01), LOW, SHOOT. The FSM also holds a `prev` register with values NONE, HIGH or LOW, which records the last switch that was on.
- HIGH/LOW -> OFF on sample 00: counter <= 1, prev <= the switch that was on.
- OFF on 00: counter increments and saturates at 2^CNT_WIDTH-1.
- OFF -> HIGH/LOW: if prev is the opposite switch:
  - o_dt_legN <= counter and the valid pulse fires.
  - o_fault_dt is set if counter < MIN_DEADTIME.
- OFF -> HIGH/LOW with prev NONE or the same switch: no measurement and no pulse.
- HIGH -> LOW (or LOW -> HIGH) directly, with no 00 sample: o_dt_legN <= 0, valid pulse fires, and o_fault_dt is set when MIN_DEADTIME > 0.
- Sample 11 in any state -> SHOOT, and o_fault_shoot is set. SHOOT holds while 11 persists.
- Leaving SHOOT: go to the state matching the sample, with prev <= NONE. The next commutation is therefore not measured.
- Latched faults hold until i_clear. If a set condition and i_clear occur in the same cycle, the set wins.
- o_dt_legN holds its value between measurements.
- The two legs are fully independent. Simultaneous events on both legs are each handled in the same cycle.

## Timing
- Reset values:
  - All outputs 0, s_q = 0.
  - FSMs in OFF, prev = NONE, counters 0.
- Measured value equals the number of rising clock edges at which i_signal's leg pair was 00, saturating at 2^CNT_WIDTH-1.
- Latency:
  - i_signal changes before edge k -> s_q at edge k.
  - FSM, o_dt_legN, o_dt_valid and fault bits update at edge k+1.
  - o_fault updates at edge k+2.
- o_dt_valid is high for exactly one cycle per measurement.
- Asserting reset mid-measurement aborts it: no pulse is produced and prev returns to NONE.
- i_clear deasserted -> faults stay latched indefinitely.

## Structure
- Shared package dead_time_pkg holds:
  - the leg state encoding (OFF, HIGH, LOW, SHOOT);
  - the prev encoding (NONE, HIGH, LOW);
  - the bit-index constants for leg0/leg1 high/low.
- Sub-module dead_time_leg_monitor contains the per-leg FSM, counter, measurement register and two fault latches. It is instantiated twice.
- The top level contains only the input register, the two instances and the o_fault OR register.

## Test plan
- Leg0 commutation with a clean off interval:
  - Stimulus: i_signal 0001 for 20 cycles, 0000 for 12 cycles, then 0010.
  - Response: o_dt_leg0 = 12 with a one-cycle valid[0] pulse two edges after 0010 is applied; no fault.
- Dead time below the minimum:
  - Stimulus: same sequence with an off interval of 7 cycles (MIN_DEADTIME = 10).
  - Response: o_dt_leg0 = 7 and o_fault_dt[0] = 1.
  - Then i_clear for 1 cycle -> o_fault_dt[0] = 0.
- Direct transition on leg1:
  - Stimulus: i_signal 0100 -> 1000 with no 00 sample.
  - Response: o_dt_leg1 = 0, valid[1] pulses, o_fault_dt[1] = 1, and o_fault = 1 one edge after.
- Shoot-through on leg0:
  - Stimulus: leg0 = 11 for 1 cycle, then 01, 00 for 15 cycles, then 10.
  - Response: o_fault_shoot[0] = 1.
  - The first commutation after SHOOT (01 -> off -> 10) is not measured: no valid[0] pulse.
  - A subsequent 10 -> 00 (12 cycles) -> 01 commutation is measured normally: o_dt_leg0 = 12 with a valid[0] pulse.
- Saturation and same-side re-entry:
  - Stimulus, CNT_WIDTH = 4: 01, then 00 for 40 cycles, then 10 -> o_dt_leg0 = 15.
  - Stimulus: 01 -> 00 -> 01 -> no valid pulse.
- Reset mid-interval:
  - Stimulus: i_reset_n low during a 00 interval, then 10.
  - Response: no valid pulse, all outputs 0.
  - Simultaneous i_clear and a new violation leave the fault set.
